// File: rtl/pulse_generator.sv
// Periodic pulse generator: high time = active ticks out of MAXV ticks per period,
// double-buffered length updates. Optional one-shot mode: `define PULSE_GEN_ONESHOT_EN.
module pulse_generator #(
    parameter  int PREDIV = 2,
    parameter  int MAXV   = 1024,
    localparam int CNT_W  = $clog2(MAXV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] pulse_length,
    input  logic             load,
`ifdef PULSE_GEN_ONESHOT_EN
    input  logic             trigger,
`endif
    output logic             pulse_out,
    output logic             period_stb,
    output logic             load_ack,
    output logic             busy
);

    localparam int PRE_W = (PREDIV > 1) ? $clog2(PREDIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREDIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
`ifdef PULSE_GEN_ONESHOT_EN
        , ONESHOT
`endif
    } state_t;

    state_t           state, state_n;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] shadow, shadow_n;
    logic [CNT_W-1:0] active, active_n;
    logic             pending, pending_n;
    logic [CNT_W-1:0] len_clamped;
    logic             tick, period_end, start;

    // Clamp only matters when MAXV is not a power of two.
    generate
        if ((2 ** CNT_W) == MAXV) begin : g_noclamp
            always_comb len_clamped = pulse_length;
        end else begin : g_clamp
            always_comb len_clamped = (pulse_length > CNT_MAX) ? CNT_MAX : pulse_length;
        end
    endgenerate

    always_comb begin
        tick       = (state != IDLE) && (pre_cnt == PRE_MAX);
        period_end = tick && (cnt == CNT_MAX);
        state_n    = state;
        start      = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    start   = 1'b1;
                end
`ifdef PULSE_GEN_ONESHOT_EN
                else if (trigger) begin
                    state_n = ONESHOT;
                    start   = 1'b1;
                end
`endif
            end
            RUN, STOP_PEND: begin
                if (period_end) begin
                    state_n = enable ? RUN : IDLE;
                    start   = enable;
                end else begin
                    state_n = enable ? RUN : STOP_PEND;
                end
            end
`ifdef PULSE_GEN_ONESHOT_EN
            ONESHOT: begin
                if (period_end) begin
                    state_n = enable ? RUN : IDLE;
                    start   = enable;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_n = pre_cnt;
        cnt_n     = cnt;
        if (start || (state_n == IDLE)) begin
            pre_cnt_n = '0;
            cnt_n     = '0;
        end else if (tick) begin
            // period_end always leads to start or IDLE, so cnt never overflows here
            pre_cnt_n = '0;
            cnt_n     = cnt + CNT_W'(1);
        end else begin
            pre_cnt_n = pre_cnt + PRE_W'(1);
        end
    end

    always_comb begin
        active_n  = (start && pending) ? shadow : active;
        shadow_n  = load ? len_clamped : shadow;
        pending_n = pending;
        if (load) begin
            pending_n = 1'b1;
        end else if (start) begin
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            pulse_out  <= 1'b0;
            period_stb <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            cnt        <= cnt_n;
            shadow     <= shadow_n;
            active     <= active_n;
            pending    <= pending_n;
            // Outputs are registered from next-state values so pulse_out rises with period_stb.
            pulse_out  <= (state_n != IDLE) && (cnt_n < active_n);
            period_stb <= start;
            load_ack   <= start && pending;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: period-position reference model checked
// every cycle, plus directed scenarios with literal pulse-width expectations.
module tb_pulse_generator;

    localparam int PREDIV = 2;
    localparam int MAXV   = 16;
    localparam int P      = PREDIV * MAXV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic       trigger = 1'b0;
    logic [3:0] pulse_length = '0;
    logic       pulse_out, period_stb, load_ack, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulse_generator #(.PREDIV(PREDIV), .MAXV(MAXV)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pulse_length(pulse_length),
        .load(load),
`ifdef PULSE_GEN_ONESHOT_EN
        .trigger(trigger),
`endif
        .pulse_out(pulse_out),
        .period_stb(period_stb),
        .load_ack(load_ack),
        .busy(busy)
    );

    // Reference model: position within the period in clk cycles.
    bit m_busy, m_pending, m_stb, m_ack;
    int m_pos, m_active, m_shadow;

    task automatic m_start();
        m_busy = 1;
        m_pos  = 0;
        m_stb  = 1;
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
            m_ack     = 1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_pending = 0; m_stb = 0; m_ack = 0;
            m_pos = 0; m_active = 0; m_shadow = 0;
        end else begin
            bit go;
            m_stb = 0;
            m_ack = 0;
            go = enable;
`ifdef PULSE_GEN_ONESHOT_EN
            go = go || trigger;
`endif
            if (m_busy) begin
                m_pos++;
                if (m_pos == P) begin
                    if (enable) m_start();
                    else m_busy = 0;
                end
            end else if (go) begin
                m_start();
            end
            if (load) begin
                m_shadow  = (int'(pulse_length) > MAXV - 1) ? MAXV - 1 : int'(pulse_length);
                m_pending = 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_pulse_out", int'(pulse_out), int'(m_busy && (m_pos < m_active * PREDIV)));
            check("cyc_period_stb", int'(period_stb), int'(m_stb));
            check("cyc_load_ack", int'(load_ack), int'(m_ack));
            check("cyc_busy", int'(busy), int'(m_busy));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_load(input int v);
        pulse_length = 4'(v);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_stb(input string name, input int budget);
        int n = 0;
        while (!period_stb && n < budget) begin
            step();
            n++;
        end
        check(name, int'(period_stb), 1);
    endtask

    // Called on the negedge where period_stb is high; runs one full period.
    task automatic measure(input string name, input int exp_high, input int exp_ack,
                           input int exp_stb_end, input int load_at, input int load_val,
                           input int dis_at, input int en_at);
        int high = 0;
        check({name, "_ack"}, int'(load_ack), exp_ack);
        for (int i = 0; i < P; i++) begin
            if (pulse_out) high++;
            if (i == load_at) begin
                pulse_length = 4'(load_val);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (i == dis_at) enable = 1'b0;
            if (i == en_at) enable = 1'b1;
            step();
        end
        load = 1'b0;
        check({name, "_high"}, high, exp_high);
        check({name, "_stb_end"}, int'(period_stb), exp_stb_end);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stb_cnt;
        repeat (3) step();
        check("reset_pulse_out", int'(pulse_out), 0);
        check("reset_period_stb", int'(period_stb), 0);
        check("reset_load_ack", int'(load_ack), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        step();

        // Basic train, load 5 before enabling
        pulse_load(5);
        enable = 1'b1;
        step();
        check("first_stb", int'(period_stb), 1);
        measure("len5", 10, 1, 1, -1, 0, -1, -1);
        measure("load9_mid", 10, 0, 1, 4, 9, -1, -1);
        measure("len9", 18, 1, 1, 3, 15, -1, -1);
        measure("len15", 30, 1, 1, 5, 0, -1, -1);
        measure("len0", 0, 1, 1, -1, 0, -1, -1);
        measure("len0b", 0, 0, 1, 2, 5, -1, -1);

        // Disable 3 cycles into the pulse: completes, then idles
        measure("stop", 10, 1, 0, -1, 0, 3, -1);
        check("stop_busy", int'(busy), 0);
        stb_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (period_stb) stb_cnt++;
            step();
        end
        check("idle_no_stb", stb_cnt, 0);

        // Re-enable before period end keeps the train continuous
        enable = 1'b1;
        step();
        check("restart_stb", int'(period_stb), 1);
        measure("reen", 10, 0, 1, -1, 0, 3, 20);
        measure("cont", 10, 0, 1, -1, 0, -1, -1);

        // Asynchronous reset mid-pulse
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_rst_pulse", int'(pulse_out), 0);
        check("async_rst_busy", int'(busy), 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_stb", int'(period_stb), 1);
        measure("post_rst", 0, 0, 1, -1, 0, -1, -1);

        // Randomized phase, checked cycle by cycle against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            load = ($urandom_range(0, 7) == 0);
            pulse_length = 4'($urandom);
`ifdef PULSE_GEN_ONESHOT_EN
            trigger = ($urandom_range(0, 29) == 0);
`endif
            step();
        end
        load = 1'b0;
        trigger = 1'b0;
        enable = 1'b0;

`ifdef PULSE_GEN_ONESHOT_EN
        begin
            int n = 0;
            int high = 0;
            int busy_cnt = 0;
            while (busy && n < 2 * P) begin
                step();
                n++;
            end
            check("os_idle_before", int'(busy), 0);
            pulse_load(4);
            trigger = 1'b1;
            step();
            trigger = 1'b0;
            check("os_stb", int'(period_stb), 1);
            check("os_ack", int'(load_ack), 1);
            stb_cnt = 0;
            for (int i = 0; i < P + 8; i++) begin
                if (pulse_out) high++;
                if (busy) busy_cnt++;
                if (period_stb) stb_cnt++;
                trigger = (i == 10);
                step();
            end
            trigger = 1'b0;
            check("os_high", high, 8);
            check("os_busy_cycles", busy_cnt, P);
            check("os_stb_count", stb_cnt, 1);
            check("os_idle_after", int'(busy), 0);
        end
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
